// File: rtl/run_monitor_pkg.sv
// Shared definitions for the run monitor: status codes, FSM states
// and default sizing parameters.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUNNING = 2'd0,
        ST_HALTED  = 2'd1,
        ST_STALL   = 2'd2,
        ST_LIMIT   = 2'd3
    } status_e;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_STOP = 1'b1
    } state_e;

    localparam int unsigned CW_DEF          = 16;
    localparam int unsigned MAX_CYCLES_DEF  = 1000;
    localparam int unsigned STALL_LIMIT_DEF = 64;

endpackage

// File: rtl/run_monitor_stall_timer.sv
// Counts consecutive cycles without a retire and flags the edge on
// which the forward-progress limit is reached.
module stall_timer #(
    parameter int unsigned STALL_LIMIT = 64,
    parameter int unsigned CW          = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam logic [CW-1:0] LAST = CW'(STALL_LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = clear ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/run_monitor.sv
// Run supervisor: counts cycles and retired instructions and stops the
// run on halt, cycle limit or stall, pulsing finish_req once.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned CW          = CW_DEF,
    parameter int unsigned MAX_CYCLES  = MAX_CYCLES_DEF,
    parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          halt,
    input  logic          retire,
    output logic [CW-1:0] cycles,
    output logic [CW-1:0] instret,
    output logic          done,
    output logic [1:0]    status,
    output logic          finish_req
);

    localparam logic [CW-1:0] MAXC = CW'(MAX_CYCLES);

    state_e        state_q, state_d;
    status_e       status_q, status_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic [CW-1:0] instret_q, instret_d;
    logic          done_q, done_d;
    logic          fin_q, fin_d;
    logic          stall_exp;
    logic          running;

    assign running = (state_q == S_RUN);

    stall_timer #(
        .STALL_LIMIT(STALL_LIMIT),
        .CW         (CW)
    ) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(running),
        .clear (retire),
        .expire(stall_exp)
    );

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        cycles_d  = cycles_q;
        instret_d = instret_q;
        done_d    = done_q;
        fin_d     = 1'b0;
        if (running) begin
            instret_d = instret_q + CW'(retire);
            // Priority: halt beats limit beats stall
            if (halt) begin
                status_d = ST_HALTED;
            end else if (cycles_q == MAXC) begin
                status_d = ST_LIMIT;
            end else if (stall_exp) begin
                status_d = ST_STALL;
            end
            if (halt || (cycles_q == MAXC) || stall_exp) begin
                state_d = S_STOP;
                done_d  = 1'b1;
                fin_d   = 1'b1;
            end else begin
                cycles_d = cycles_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            status_q  <= ST_RUNNING;
            cycles_q  <= '0;
            instret_q <= '0;
            done_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            cycles_q  <= cycles_d;
            instret_q <= instret_d;
            done_q    <= done_d;
            fin_q     <= fin_d;
        end
    end

    assign cycles     = cycles_q;
    assign instret    = instret_q;
    assign done       = done_q;
    assign status     = status_q;
    assign finish_req = fin_q;

endmodule
